// File: rtl/fw_tile_feeder.sv
// Tile-schedule read sequencer for the blocked Floyd-Warshall PE array: walks every round's
// tiles in dependency order, issues word reads, and streams the returned data with tile type.
module fw_tile_feeder #(
    parameter int N       = 16,
    parameter int B       = 4,
    parameter int L       = 2,
    parameter int WIDTH   = 8,
    parameter int AW      = 7,
    parameter int MAX_OUT = 4,
    localparam int T      = N / B,
    localparam int RW     = (T > 1) ? $clog2(T) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_addr,
    input  logic [L*WIDTH-1:0] mem_rdata,
    input  logic               mem_rvalid,
    output logic               out_valid,
    output logic [L*WIDTH-1:0] dOut,
    output logic [1:0]         phase,
    output logic [RW-1:0]      round
);

    localparam logic [1:0] SELF_DEP   = 2'd0;
    localparam logic [1:0] DOUBLY_DEP = 2'd1;
    localparam logic [1:0] ROW_DEP    = 2'd2;
    localparam logic [1:0] COL_DEP    = 2'd3;

    localparam int WPR        = B / L;
    localparam int TILE_WORDS = B * B / L;
    localparam int BEATS      = 3 * TILE_WORDS;
    localparam int BW         = $clog2(BEATS);
    localparam int OCW        = $clog2(MAX_OUT + 1);
    localparam int TT         = T * T;
    localparam int TIW        = (TT > 1) ? $clog2(TT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Word address of beat b of the current tile (i,j) in round k.
    function automatic logic [AW-1:0] word_addr(input logic [1:0] typ, input int k,
                                                input int i, input int j, input int b);
        int tr;
        int tc;
        int r;
        int c;
        int rb;
        tr = i;
        tc = j;
        rb = b;
        if (b >= 2 * TILE_WORDS) begin
            rb = b - 2 * TILE_WORDS;
            r  = rb / WPR;
            c  = rb % WPR;
        end else if (typ == DOUBLY_DEP) begin
            if (b < TILE_WORDS) begin
                tr = k;
                tc = j;
            end else begin
                tr = i;
                tc = k;
                rb = b - TILE_WORDS;
            end
            r = rb / WPR;
            c = rb % WPR;
        end else begin
            // Interleaved read: even row-halves come from A, odd ones from B.
            r = b / (2 * WPR);
            c = b % WPR;
            if (((b / WPR) % 2) == 0) begin
                tr = (typ == COL_DEP) ? i : k;
                tc = (typ == COL_DEP) ? j : k;
            end else begin
                tr = (typ == ROW_DEP) ? i : k;
                tc = (typ == ROW_DEP) ? j : k;
            end
        end
        return AW'((tr * B + r) * (N / L) + tc * WPR + c);
    endfunction

    function automatic int skip_next(input int x, input int k);
        int n;
        n = x + 1;
        if (n == k) begin
            n = n + 1;
        end else begin
            n = n;
        end
        return n;
    endfunction

    function automatic logic [1:0] tile_phase(input int idx);
        logic [1:0] p;
        if (idx == 0) begin
            p = SELF_DEP;
        end else if (idx < T) begin
            p = ROW_DEP;
        end else if (idx < 2 * T - 1) begin
            p = COL_DEP;
        end else begin
            p = DOUBLY_DEP;
        end
        return p;
    endfunction

    state_t           state_r, state_s;
    logic             busy_r, done_r, err_r, rd_en_r, out_valid_r;
    logic [AW-1:0]    addr_r, addr_s;
    logic [L*WIDTH-1:0] dout_r;
    logic [1:0]       phase_r;
    logic [OCW-1:0]   out_cnt_r;
    logic             issue_s, ret_s, stray_s, last_req_s, round_end_s, run_end_s;

    logic [RW-1:0]    q_k_r, q_i_r, q_j_r, q_k_s, q_i_s, q_j_s;
    logic [1:0]       q_type_r, q_type_s;
    logic [BW-1:0]    q_beat_r, q_beat_s;
    int               k_int_s, ni_s, nj_s, fo_s;

    logic [BW-1:0]    o_beat_r, o_beat_s;
    logic [TIW-1:0]   o_tile_r, o_tile_s;
    logic [RW-1:0]    o_round_r, o_round_s;

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign mem_rd_en = rd_en_r;
    assign mem_addr  = addr_r;
    assign out_valid = out_valid_r;
    assign dOut      = dout_r;
    assign phase     = phase_r;
    assign round     = o_round_r;

    assign issue_s = (state_r == ST_ISSUE) && (out_cnt_r < OCW'(MAX_OUT));
    assign ret_s   = mem_rvalid && (out_cnt_r != '0);
    assign stray_s = mem_rvalid && (out_cnt_r == '0);
    assign k_int_s = int'(q_k_r);
    assign ni_s    = skip_next(int'(q_i_r), k_int_s);
    assign nj_s    = skip_next(int'(q_j_r), k_int_s);
    assign fo_s    = (k_int_s == 0) ? 1 : 0;
    assign addr_s  = word_addr(q_type_r, k_int_s, int'(q_i_r), int'(q_j_r), int'(q_beat_r));

    // Request-side walk: beat within tile, tile within round, round within run.
    always_comb begin
        q_beat_s    = q_beat_r;
        q_k_s       = q_k_r;
        q_i_s       = q_i_r;
        q_j_s       = q_j_r;
        q_type_s    = q_type_r;
        round_end_s = 1'b0;
        last_req_s  = 1'b0;
        if (issue_s && (q_beat_r != BW'(BEATS - 1))) begin
            q_beat_s = q_beat_r + 1'b1;
        end else if (issue_s) begin
            q_beat_s = '0;
            case (q_type_r)
                SELF_DEP: begin
                    if (T == 1) begin
                        round_end_s = 1'b1;
                    end else begin
                        q_type_s = ROW_DEP;
                        q_j_s    = RW'(fo_s);
                    end
                end
                ROW_DEP: begin
                    if (nj_s < T) begin
                        q_j_s = RW'(nj_s);
                    end else begin
                        q_type_s = COL_DEP;
                        q_j_s    = q_k_r;
                        q_i_s    = RW'(fo_s);
                    end
                end
                COL_DEP: begin
                    if (ni_s < T) begin
                        q_i_s = RW'(ni_s);
                    end else begin
                        q_type_s = DOUBLY_DEP;
                        q_i_s    = RW'(fo_s);
                        q_j_s    = RW'(fo_s);
                    end
                end
                DOUBLY_DEP: begin
                    if (nj_s < T) begin
                        q_j_s = RW'(nj_s);
                    end else if (ni_s < T) begin
                        q_i_s = RW'(ni_s);
                        q_j_s = RW'(fo_s);
                    end else begin
                        round_end_s = 1'b1;
                    end
                end
                default: round_end_s = 1'b1;
            endcase
            if (round_end_s && (k_int_s == T - 1)) begin
                last_req_s = 1'b1;
                q_type_s   = SELF_DEP;
                q_k_s      = '0;
                q_i_s      = '0;
                q_j_s      = '0;
            end else if (round_end_s) begin
                q_type_s = SELF_DEP;
                q_k_s    = q_k_r + 1'b1;
                q_i_s    = q_k_r + 1'b1;
                q_j_s    = q_k_r + 1'b1;
            end else begin
                last_req_s = 1'b0;
            end
        end else begin
            q_beat_s = q_beat_r;
        end
    end

    // Request-side state transitions.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = start ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_s = last_req_s ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_s = run_end_s ? ST_IDLE : ST_DRAIN;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Request-side registers, outstanding count and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            addr_r    <= '0;
            err_r     <= 1'b0;
            out_cnt_r <= '0;
            q_k_r     <= '0;
            q_i_r     <= '0;
            q_j_r     <= '0;
            q_type_r  <= SELF_DEP;
            q_beat_r  <= '0;
        end else begin
            state_r  <= state_s;
            busy_r   <= (state_s != ST_IDLE);
            rd_en_r  <= issue_s;
            q_k_r    <= q_k_s;
            q_i_r    <= q_i_s;
            q_j_r    <= q_j_s;
            q_type_r <= q_type_s;
            q_beat_r <= q_beat_s;
            if (issue_s) begin
                addr_r <= addr_s;
            end
            case ({issue_s, ret_s})
                2'b10:   out_cnt_r <= out_cnt_r + 1'b1;
                2'b01:   out_cnt_r <= out_cnt_r - 1'b1;
                default: out_cnt_r <= out_cnt_r;
            endcase
            if (stray_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Output-side position, advanced only by delivered beats.
    always_comb begin
        o_beat_s  = o_beat_r;
        o_tile_s  = o_tile_r;
        o_round_s = o_round_r;
        run_end_s = 1'b0;
        if (out_valid_r && (o_beat_r != BW'(BEATS - 1))) begin
            o_beat_s = o_beat_r + 1'b1;
        end else if (out_valid_r && (o_tile_r != TIW'(TT - 1))) begin
            o_beat_s = '0;
            o_tile_s = o_tile_r + 1'b1;
        end else if (out_valid_r && (o_round_r != RW'(T - 1))) begin
            o_beat_s  = '0;
            o_tile_s  = '0;
            o_round_s = o_round_r + 1'b1;
        end else if (out_valid_r) begin
            o_beat_s  = '0;
            o_tile_s  = '0;
            o_round_s = '0;
            run_end_s = 1'b1;
        end else begin
            run_end_s = 1'b0;
        end
    end

    // Output stream registers; phase follows the tile of the next beat to deliver.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            phase_r     <= SELF_DEP;
            o_beat_r    <= '0;
            o_tile_r    <= '0;
            o_round_r   <= '0;
            done_r      <= 1'b0;
        end else begin
            out_valid_r <= ret_s;
            if (ret_s) begin
                dout_r <= mem_rdata;
            end
            o_beat_r  <= o_beat_s;
            o_tile_r  <= o_tile_s;
            o_round_r <= o_round_s;
            phase_r   <= tile_phase(int'(o_tile_s));
            done_r    <= run_end_s;
        end
    end

endmodule
